vocab_detokenizer: RTL

- Inverse of the vocabulary matcher: given a token index, walks the null-terminated vocabulary memory to the N-th word.
- Copies that word, including its terminating null, into the input/output character buffer through a write port.
- Sits beside the matcher on the same vocabulary memory (asynchronous read) and the same character buffer (synchronous write), so matcher-produced indices can be turned back into text.

---
 rtl/vocab_detokenizer_if.sv | 33 +++
 rtl/vocab_detokenizer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vocab_detokenizer_if.sv
// Lookup request, vocabulary read port and buffer write port between a requester and the detokenizer.
// Signal prefixes are from the detokenizer's side: i_ into it, o_ out of it.
interface vocab_detokenizer_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_WIDTH  = 4
);
   logic                  i_cs;
   logic [IDX_WIDTH-1:0]  i_token_idx;
   logic [ADDR_WIDTH-1:0] i_vocab_start_addr;
   logic [ADDR_WIDTH-1:0] i_vocab_end_addr;
   logic [ADDR_WIDTH-1:0] i_output_start_addr;
   logic [DATA_WIDTH-1:0] i_val_vocab;
   logic [ADDR_WIDTH-1:0] o_addr_v;
   logic [ADDR_WIDTH-1:0] o_addr_o;
   logic [DATA_WIDTH-1:0] o_val_out;
   logic                  o_we;
   logic                  o_done;
   logic                  o_found;
   logic                  o_err;

   modport master (
      output i_cs, i_token_idx, i_vocab_start_addr, i_vocab_end_addr,
             i_output_start_addr, i_val_vocab,
      input  o_addr_v, o_addr_o, o_val_out, o_we, o_done, o_found, o_err
   );

   modport slave (
      input  i_cs, i_token_idx, i_vocab_start_addr, i_vocab_end_addr,
             i_output_start_addr, i_val_vocab,
      output o_addr_v, o_addr_o, o_val_out, o_we, o_done, o_found, o_err
   );
endinterface

// File: rtl/vocab_detokenizer.sv
// Walks the null-terminated vocabulary to word N and copies it, terminator included, into the char buffer.
// Last write 1 + bytes skipped + 1 + word length + 1 edges after start, flags one edge later; no backpressure, cs holds the result.
module vocab_detokenizer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_WIDTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   vocab_detokenizer_if.slave io_bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEEK,
      ST_COPY,
      ST_DONE,
      ST_NF,
      ST_ERR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [IDX_WIDTH:0]    CNT_ONE  = 1;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr_v, w_addr_v_nxt;
   logic [ADDR_WIDTH-1:0] r_addr_o, w_addr_o_nxt;
   logic [ADDR_WIDTH-1:0] r_wptr, w_wptr_nxt;
   logic [DATA_WIDTH-1:0] r_val_out, w_val_out_nxt;
   logic [IDX_WIDTH-1:0]  r_idx, w_idx_nxt;
   logic [IDX_WIDTH:0]    r_count, w_count_nxt;
   logic                  r_we, w_we_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_found, w_found_nxt;
   logic                  r_err, w_err_nxt;

   logic                  w_at_end;
   logic                  w_is_null;
   logic                  w_count_hit;

   assign w_at_end    = (r_addr_v == io_bus.i_vocab_end_addr);
   assign w_is_null   = (io_bus.i_val_vocab == '0);
   assign w_count_hit = (r_count == {1'b0, r_idx});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_addr_v  <= '0;
         r_addr_o  <= '0;
         r_wptr    <= '0;
         r_val_out <= '0;
         r_idx     <= '0;
         r_count   <= '0;
         r_we      <= 1'b0;
         r_done    <= 1'b0;
         r_found   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr_v  <= w_addr_v_nxt;
         r_addr_o  <= w_addr_o_nxt;
         r_wptr    <= w_wptr_nxt;
         r_val_out <= w_val_out_nxt;
         r_idx     <= w_idx_nxt;
         r_count   <= w_count_nxt;
         r_we      <= w_we_nxt;
         r_done    <= w_done_nxt;
         r_found   <= w_found_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_v_nxt  = r_addr_v;
      w_addr_o_nxt  = r_addr_o;
      w_wptr_nxt    = r_wptr;
      w_val_out_nxt = r_val_out;
      w_idx_nxt     = r_idx;
      w_count_nxt   = r_count;
      w_we_nxt      = 1'b0;
      w_done_nxt    = r_done;
      w_found_nxt   = r_found;
      w_err_nxt     = r_err;

      case (r_state)
         ST_IDLE: begin
            w_addr_v_nxt = io_bus.i_vocab_start_addr;
            w_count_nxt  = '0;
            w_done_nxt   = 1'b0;
            w_found_nxt  = 1'b0;
            w_err_nxt    = 1'b0;
            if (io_bus.i_cs) begin
               w_idx_nxt   = io_bus.i_token_idx;
               w_wptr_nxt  = io_bus.i_output_start_addr;
               w_state_nxt = ST_SEEK;
            end
         end

         // End-of-vocabulary wins over a count match, so a word starting at the end is "not found".
         ST_SEEK: begin
            if (w_at_end) begin
               w_state_nxt = ST_NF;
            end else if (w_count_hit) begin
               w_state_nxt = ST_COPY;
            end else begin
               w_addr_v_nxt = r_addr_v + ADDR_ONE;
               if (w_is_null) begin
                  w_count_nxt = r_count + CNT_ONE;
               end
            end
         end

         ST_COPY: begin
            w_we_nxt     = 1'b1;
            w_addr_o_nxt = r_wptr;
            if (w_at_end) begin
               w_val_out_nxt = '0;
               w_state_nxt   = ST_ERR;
            end else if (w_is_null) begin
               w_val_out_nxt = '0;
               w_state_nxt   = ST_DONE;
            end else begin
               w_val_out_nxt = io_bus.i_val_vocab;
               w_wptr_nxt    = r_wptr + ADDR_ONE;
               w_addr_v_nxt  = r_addr_v + ADDR_ONE;
            end
         end

         // Flags follow the terminal state one edge late; IDLE clears them after cs drops.
         ST_DONE, ST_NF, ST_ERR: begin
            w_done_nxt  = 1'b1;
            w_found_nxt = (r_state == ST_DONE);
            w_err_nxt   = (r_state == ST_ERR);
            if (!io_bus.i_cs) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign io_bus.o_addr_v  = r_addr_v;
   assign io_bus.o_addr_o  = r_addr_o;
   assign io_bus.o_val_out = r_val_out;
   assign io_bus.o_we      = r_we;
   assign io_bus.o_done    = r_done;
   assign io_bus.o_found   = r_found;
   assign io_bus.o_err     = r_err;

endmodule
